dram_slink_init_ctrl: RTL and testbench



---
 rtl/dram_slink_init_pkg.sv | 53 +++++
 rtl/dram_slink_init_ctrl_timer.sv | 37 +++
 rtl/dram_slink_init_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_dram_slink_init_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_slink_init_pkg.sv
// Shared definitions for the DRAM serial-link bring-up sequencer:
// register map, CTRL bit positions, FSM state type and small helpers.
package dram_slink_init_pkg;

   localparam logic [7:0] SlinkRegCtrl     = 8'h00;
   localparam logic [7:0] SlinkRegIsolated = 8'h04;
   localparam logic [7:0] SlinkRegIsolate  = 8'h08;
   localparam logic [7:0] SlinkRegTxClkDiv = 8'h0C;

   localparam int unsigned CtrlClkEnaBit  = 0;
   localparam int unsigned CtrlResetNBit  = 1;
   localparam int unsigned SlinkMaxClkDiv = 1024;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_W_CLKEN = 4'd1,
      S_W_ISO   = 4'd2,
      S_W_DIV   = 4'd3,
      S_W_RST   = 4'd4,
      S_W_DEISO = 4'd5,
      S_R_STAT  = 4'd6,
      S_GAP     = 4'd7,
      S_DONE    = 4'd8,
      S_FAIL    = 4'd9
   } slink_init_state_e;

   function automatic logic [31:0] slink_ctrl_word(input logic clk_ena, input logic reset_n);
      logic [31:0] w;
      w                = 32'h0000_0000;
      w[CtrlClkEnaBit] = clk_ena;
      w[CtrlResetNBit] = reset_n;
      return w;
   endfunction

   // A write state holds until its access is accepted; a bus error aborts the sequence.
   function automatic slink_init_state_e slink_write_next(
      input logic              acc,
      input logic              bus_err,
      input slink_init_state_e cur,
      input slink_init_state_e nxt
   );
      slink_init_state_e res;
      if (!acc) begin
         res = cur;
      end else if (bus_err) begin
         res = S_FAIL;
      end else begin
         res = nxt;
      end
      return res;
   endfunction

endpackage

// File: rtl/dram_slink_init_ctrl_timer.sv
// Loadable down-counter used for the poll gap and the polling timeout.
// done_o is high while the count is zero.
module slink_init_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dram_slink_init_ctrl.sv
// Bring-up sequencer for the DRAM serial link: drives the link's regbus config
// port through enable/reset/divider/de-isolation, then polls until the link is up.
module dram_slink_init_ctrl
   import dram_slink_init_pkg::*;
#(
   parameter int unsigned          AddrWidth     = 48,
   parameter int unsigned          DataWidth     = 32,
   parameter logic [AddrWidth-1:0] BaseAddr      = '0,
   parameter int unsigned          ClkDiv        = 8,
   parameter int unsigned          PollGap       = 16,
   parameter int unsigned          TimeoutCycles = 4096,
   parameter int unsigned          MaxRetries    = 3,
   localparam int unsigned         AttW          = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o,
   output logic [AttW-1:0]        attempt_o,
   output logic [AddrWidth-1:0]   reg_addr_o,
   output logic                   reg_write_o,
   output logic [DataWidth-1:0]   reg_wdata_o,
   output logic [DataWidth/8-1:0] reg_wstrb_o,
   output logic                   reg_valid_o,
   input  logic [DataWidth-1:0]   reg_rdata_i,
   input  logic                   reg_error_i,
   input  logic                   reg_ready_i
);

   localparam int unsigned     TmoW       = $clog2(TimeoutCycles + 1);
   localparam int unsigned     GapW       = $clog2(PollGap + 1);
   localparam logic [AttW-1:0] MaxAttempt = AttW'(MaxRetries);
   localparam logic [TmoW-1:0] TmoLoad    = TmoW'(TimeoutCycles);
   localparam logic [GapW-1:0] GapLoad    = GapW'(PollGap);

   slink_init_state_e state_q, state_d;
   slink_init_state_e retry_state_s;

   logic                   valid_q, valid_d;
   logic                   write_q, write_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
   logic [AttW-1:0]        attempt_q, attempt_d;
   logic                   busy_q, done_q, error_q;

   logic                 acc_s, polling_s, stat_ok_s, restart_s, issue_s;
   logic                 acc_is_s, acc_wr_s;
   logic [7:0]           acc_off_s;
   logic [DataWidth-1:0] acc_data_s;
   logic                 tmo_load_s, tmo_en_s, tmo_done_s;
   logic                 gap_load_s, gap_en_s, gap_done_s;
   logic                 unused_rdata_s;

   assign acc_s          = valid_q & reg_ready_i;
   assign polling_s      = (state_q == S_R_STAT) || (state_q == S_GAP);
   assign stat_ok_s      = (reg_rdata_i[1:0] == 2'b00);
   assign restart_s      = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
   assign retry_state_s  = (attempt_q < MaxAttempt) ? S_W_CLKEN : S_FAIL;
   assign unused_rdata_s = ^reg_rdata_i[DataWidth-1:2];

   slink_init_timer #(.Width(GapW)) i_gap_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (gap_load_s),
      .load_val_i (GapLoad),
      .en_i       (gap_en_s),
      .done_o     (gap_done_s)
   );

   slink_init_timer #(.Width(TmoW)) i_tmo_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmo_load_s),
      .load_val_i (TmoLoad),
      .en_i       (tmo_en_s),
      .done_o     (tmo_done_s)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A read accepted in the timeout cycle is judged first, so a good status still wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start_i) begin
               state_d = S_W_CLKEN;
            end else begin
               state_d = state_q;
            end
         end
         S_W_CLKEN: state_d = slink_write_next(acc_s, reg_error_i, state_q, S_W_ISO);
         S_W_ISO:   state_d = slink_write_next(acc_s, reg_error_i, state_q, S_W_DIV);
         S_W_DIV:   state_d = slink_write_next(acc_s, reg_error_i, state_q, S_W_RST);
         S_W_RST:   state_d = slink_write_next(acc_s, reg_error_i, state_q, S_W_DEISO);
         S_W_DEISO: state_d = slink_write_next(acc_s, reg_error_i, state_q, S_R_STAT);
         S_R_STAT: begin
            if (acc_s) begin
               if (reg_error_i) begin
                  state_d = S_FAIL;
               end else if (stat_ok_s) begin
                  state_d = S_DONE;
               end else if (tmo_done_s) begin
                  state_d = retry_state_s;
               end else begin
                  state_d = S_GAP;
               end
            end else if (!valid_q && tmo_done_s) begin
               state_d = retry_state_s;
            end else begin
               state_d = S_R_STAT;
            end
         end
         S_GAP: begin
            if (tmo_done_s) begin
               state_d = retry_state_s;
            end else if (gap_done_s) begin
               state_d = S_R_STAT;
            end else begin
               state_d = S_GAP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Requests are only raised from an idle bus, which leaves one idle cycle after each acceptance.
   always_comb begin
      acc_is_s   = 1'b1;
      acc_wr_s   = 1'b1;
      acc_off_s  = SlinkRegCtrl;
      acc_data_s = '0;
      case (state_q)
         S_W_CLKEN: begin
            acc_off_s  = SlinkRegCtrl;
            acc_data_s = DataWidth'(slink_ctrl_word(1'b1, 1'b0));
         end
         S_W_ISO: begin
            acc_off_s  = SlinkRegIsolate;
            acc_data_s = DataWidth'(32'h0000_0003);
         end
         S_W_DIV: begin
            acc_off_s  = SlinkRegTxClkDiv;
            acc_data_s = DataWidth'(ClkDiv);
         end
         S_W_RST: begin
            acc_off_s  = SlinkRegCtrl;
            acc_data_s = DataWidth'(slink_ctrl_word(1'b1, 1'b1));
         end
         S_W_DEISO: begin
            acc_off_s  = SlinkRegIsolate;
            acc_data_s = '0;
         end
         S_R_STAT: begin
            acc_off_s = SlinkRegIsolated;
            acc_wr_s  = 1'b0;
         end
         default: begin
            acc_is_s = 1'b0;
            acc_wr_s = 1'b0;
         end
      endcase

      issue_s = acc_is_s && !valid_q && (state_d == state_q);
      valid_d = valid_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      if (acc_s) begin
         valid_d = 1'b0;
      end else if (issue_s) begin
         valid_d = 1'b1;
         write_d = acc_wr_s;
         addr_d  = BaseAddr + AddrWidth'(acc_off_s);
         wdata_d = acc_data_s;
         wstrb_d = '1;
      end else begin
         valid_d = valid_q;
      end

      tmo_load_s = (state_q == S_W_DEISO) && acc_s;
      tmo_en_s   = polling_s;
      gap_load_s = (state_q == S_R_STAT) && (state_d == S_GAP);
      gap_en_s   = (state_q == S_GAP);

      if (restart_s) begin
         attempt_d = '0;
      end else if (polling_s && (state_d == S_W_CLKEN)) begin
         attempt_d = attempt_q + AttW'(1);
      end else begin
         attempt_d = attempt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q   <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         attempt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         attempt_q <= attempt_d;
         busy_q    <= (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
         done_q    <= (state_q == S_DONE);
         error_q   <= (state_q == S_FAIL);
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign attempt_o   = attempt_q;
   assign reg_valid_o = valid_q;
   assign reg_write_o = write_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_dram_slink_init_ctrl.sv
// Scoreboard bench for the serial-link bring-up sequencer: a regbus responder
// with configurable backpressure, status and error injection.
module tb_dram_slink_init_ctrl;

   localparam logic [47:0] BASE     = 48'h0000_1000_0000;
   localparam int          POLL_GAP = 4;
   localparam int          TMO      = 64;
   localparam int          RETRIES  = 1;
   localparam int          CLK_DIV  = 8;

   typedef struct packed {
      logic [47:0] addr;
      logic        wr;
      logic [31:0] data;
   } acc_t;

   logic        clk, rst_n, start;
   logic        busy, done, error;
   logic [0:0]  attempt;
   logic [47:0] addr;
   logic        wr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        valid;
   logic [31:0] rdata;
   logic        rerr;
   logic        rdy;

   acc_t exp_q[$];
   int   chk_n = 0;
   int   fail_n = 0;
   int   cyc = 0;
   int   ready_delay = 0;
   int   stat_busy_n = 0;
   bit   skip_reads = 1'b0;
   bit   err_en = 1'b0;
   logic [47:0] err_addr = 48'h0;
   int   err_cyc = 0;
   int   end_cyc;

   dram_slink_init_ctrl #(
      .AddrWidth     (48),
      .DataWidth     (32),
      .BaseAddr      (BASE),
      .ClkDiv        (CLK_DIV),
      .PollGap       (POLL_GAP),
      .TimeoutCycles (TMO),
      .MaxRetries    (RETRIES)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .error_o     (error),
      .attempt_o   (attempt),
      .reg_addr_o  (addr),
      .reg_write_o (wr),
      .reg_wdata_o (wdata),
      .reg_wstrb_o (wstrb),
      .reg_valid_o (valid),
      .reg_rdata_i (rdata),
      .reg_error_i (rerr),
      .reg_ready_i (rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_n++;
      if (act !== exp) begin
         fail_n++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_write(input logic [7:0] off, input logic [31:0] data);
      acc_t e;
      e.addr = BASE + {40'h0, off};
      e.wr   = 1'b1;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic push_read();
      acc_t e;
      e.addr = BASE + 48'h4;
      e.wr   = 1'b0;
      e.data = 32'h0;
      exp_q.push_back(e);
   endtask

   task automatic push_init_seq();
      push_write(8'h00, 32'h1);
      push_write(8'h08, 32'h3);
      push_write(8'h0C, 32'd8);
      push_write(8'h00, 32'h3);
      push_write(8'h08, 32'h0);
   endtask

   task automatic configure(input int delay, input int busy_n, input bit skip, input bit inj);
      @(negedge clk);
      #1;
      ready_delay = delay;
      stat_busy_n = busy_n;
      skip_reads  = skip;
      err_en      = inj;
      err_addr    = BASE + 48'hC;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", {63'h0, busy}, 64'h1);
   endtask

   task automatic wait_end(input int budget, output int ec);
      ec = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done || error) begin
            ec = cyc;
            break;
         end
      end
      if (ec < 0) chk("end_wait_expired", 64'h0, 64'h1);
   endtask

   task automatic check_final(input string name, input logic d, input logic e, input logic a);
      repeat (4) @(negedge clk);
      chk({name, "_done"}, {63'h0, done}, {63'h0, d});
      chk({name, "_error"}, {63'h0, error}, {63'h0, e});
      chk({name, "_attempt"}, {63'h0, attempt}, {63'h0, a});
      chk({name, "_busy"}, {63'h0, busy}, 64'h0);
      chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
   endtask

   // Responder and monitor: ready/rdata/error are set on the falling edge, so
   // valid && ready seen here is exactly the access accepted at the next rising edge.
   initial begin
      int   wait_cnt;
      int   read_cnt;
      int   idle_cnt;
      bit   hold_v;
      bit   prev_acc;
      bit   last_read;
      logic [47:0] hold_addr;
      logic [31:0] hold_wdata;
      acc_t e;
      wait_cnt = 0; read_cnt = 0; idle_cnt = 0;
      hold_v = 1'b0; prev_acc = 1'b0; last_read = 1'b0;
      hold_addr = 48'h0; hold_wdata = 32'h0;
      rdy = 1'b0; rdata = 32'h0; rerr = 1'b0;
      forever begin
         @(negedge clk);
         if (!busy) read_cnt = 0;
         if (ready_delay == 0) begin
            rdy = 1'b1;
         end else if (valid && wait_cnt >= ready_delay) begin
            rdy = 1'b1;
         end else begin
            rdy = 1'b0;
            if (valid) wait_cnt++;
            else wait_cnt = 0;
         end
         rdata = (stat_busy_n < 0 || read_cnt < stat_busy_n) ? 32'h3 : 32'h0;
         rerr  = err_en && valid && (addr == err_addr);

         if (valid && hold_v) begin
            chk("hold_addr", {16'h0, addr}, {16'h0, hold_addr});
            chk("hold_wdata", {32'h0, wdata}, {32'h0, hold_wdata});
         end
         hold_v     = valid && !rdy;
         hold_addr  = addr;
         hold_wdata = wdata;
         if (prev_acc) chk("idle_after_accept", {63'h0, valid}, 64'h0);
         if (valid) chk("wstrb", {60'h0, wstrb}, 64'hF);
         prev_acc = valid && rdy;
         if (!valid) idle_cnt++;

         if (valid && rdy) begin
            if (rerr) err_cyc = cyc;
            if (!wr) begin
               if (last_read) chk("poll_spacing", {63'h0, (idle_cnt >= POLL_GAP)}, 64'h1);
               read_cnt++;
            end
            last_read = !wr;
            idle_cnt  = 0;
            if (skip_reads && !wr) begin
               idle_cnt = 0;
            end else if (exp_q.size() == 0) begin
               chk("unexpected_access", {16'h0, addr}, 64'h0);
            end else begin
               e = exp_q.pop_front();
               chk("acc_addr", {16'h0, addr}, {16'h0, e.addr});
               chk("acc_write", {63'h0, wr}, {63'h0, e.wr});
               if (e.wr) chk("acc_wdata", {32'h0, wdata}, {32'h0, e.data});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {63'h0, valid}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_error", {63'h0, error}, 64'h0);
      chk("rst_attempt", {63'h0, attempt}, 64'h0);
      chk("rst_addr", {16'h0, addr}, 64'h0);
      chk("rst_wstrb", {60'h0, wstrb}, 64'h0);
      rst_n = 1'b1;

      // nominal
      configure(0, 0, 1'b0, 1'b0);
      push_init_seq();
      push_read();
      pulse_start();
      wait_end(2000, end_cyc);
      check_final("nominal", 1'b1, 1'b0, 1'b0);

      // backpressure, restarted from DONE
      configure(5, 0, 1'b0, 1'b0);
      push_init_seq();
      push_read();
      pulse_start();
      wait_end(2000, end_cyc);
      check_final("backpressure", 1'b1, 1'b0, 1'b0);

      // slow link: four busy polls then up
      configure(0, 4, 1'b0, 1'b0);
      push_init_seq();
      repeat (5) push_read();
      pulse_start();
      wait_end(2000, end_cyc);
      check_final("slow", 1'b1, 1'b0, 1'b0);

      // link never comes up: two full attempts then FAIL
      configure(0, -1, 1'b1, 1'b0);
      push_init_seq();
      push_init_seq();
      pulse_start();
      wait_end(3000, end_cyc);
      check_final("timeout", 1'b0, 1'b1, 1'b1);

      // bus error on TX_CLK_DIV write
      configure(0, 0, 1'b0, 1'b1);
      push_write(8'h00, 32'h1);
      push_write(8'h08, 32'h3);
      push_write(8'h0C, 32'd8);
      pulse_start();
      wait_end(2000, end_cyc);
      chk("err_latency", 64'(end_cyc - err_cyc), 64'd2);
      repeat (20) @(negedge clk);
      check_final("buserr", 1'b0, 1'b1, 1'b0);
      configure(0, 0, 1'b0, 1'b0);
      push_init_seq();
      push_read();
      pulse_start();
      wait_end(2000, end_cyc);
      check_final("buserr_restart", 1'b1, 1'b0, 1'b0);

      // reset while a request is held by backpressure
      configure(1000, 0, 1'b0, 1'b0);
      pulse_start();
      end_cyc = -1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (valid) begin
            end_cyc = cyc;
            break;
         end
      end
      chk("midrst_valid_seen", {63'h0, (end_cyc >= 0)}, 64'h1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {63'h0, valid}, 64'h0);
      chk("midrst_busy", {63'h0, busy}, 64'h0);
      chk("midrst_done", {63'h0, done}, 64'h0);
      chk("midrst_error", {63'h0, error}, 64'h0);
      chk("midrst_addr", {16'h0, addr}, 64'h0);
      chk("midrst_wdata", {32'h0, wdata}, 64'h0);
      chk("midrst_write", {63'h0, wr}, 64'h0);
      chk("midrst_wstrb", {60'h0, wstrb}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      configure(0, 0, 1'b0, 1'b0);
      push_init_seq();
      push_read();
      pulse_start();
      wait_end(2000, end_cyc);
      check_final("after_reset", 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
      $finish;
   end

endmodule
